task_dispatch_scheduler: RTL
============================

Name: task_dispatch_scheduler

Overview:
- Sits directly downstream of the ready-list/delay-list manager and consumes its ready-list outputs: highest priority, highest-priority task pointer, next-task pointer and the TCB read port.
- Generates the system tick: the tick counter value it produces feeds the delay list's tickval input.
- Decides preemption and round-robin, fetches the chosen task's TCB address and id over the read port, and raises a context-switch request to the CPU.
- Holds that request until the CPU acknowledges, then commits the new current task.

Parameters:
- TICK_DIV, 100000, aclk cycles per system tick (≥2).
- NULL_PTR, 8'hFF, pointer value meaning "list empty / no task".

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- sched_en_in  in  1  scheduler and tick enable
- yield_in  in  1  single-cycle software yield request
- highpriority_in  in  6  highest ready priority; larger value = more urgent
- ptr_hpritask_in  in  8  pointer to head task of highest priority
- ptr_nexttask_in  in  8  pointer to next task at the same priority (round-robin)
- addr_read_out  out  8  TCB read address to the list manager
- tcb_read_in  in  32  TCB address at addr_read_out, valid 1 cycle after address
- id_task_in  in  8  task id at addr_read_out, same timing as tcb_read_in
- tickval_out  out  32  free-running tick count
- tick_out  out  1  single-cycle pulse on each tick
- ctxsw_req_out  out  1  context-switch request
- next_tcb_out  out  32  TCB address of the incoming task
- next_id_out  out  8  id of the incoming task
- ctxsw_ack_in  in  1  CPU acknowledge
- cur_id_out  out  8  currently running task id
- cur_valid_out  out  1  a task is currently running

Behaviour:
- Reset: aresetn is synchronous, active-low, sampled on the rising edge of aclk. All outputs and registers go to 0: tick counter, pending flags, cur_prio, cur_ptr; FSM to IDLE.
- Reset mid-request: ctxsw_req_out drops on the next edge.
- Tick:
  - Counter runs only while sched_en_in=1 and holds otherwise.
  - When the counter equals TICK_DIV-1: tick_out=1 for one cycle, the counter returns to 0, tickval_out increments (wraps 2^32-1 → 0).
- Event capture, in every state:
  - tick_out or yield_in sets rr_pend.
  - Any change of {highpriority_in, ptr_hpritask_in} against last cycle's registered copy sets chg_pend.
  - Flags clear only when EVAL consumes them. An event arriving in the same cycle as the clear is kept.
- FSM:
  - IDLE: if sched_en_in & (rr_pend | chg_pend) → EVAL.
  - EVAL: clear both flags and choose a candidate:
    - ptr_hpritask_in==NULL_PTR → IDLE, no request.
    - !cur_valid or highpriority_in > cur_prio → candidate = ptr_hpritask_in (preempt).
    - Else if rr_pend was set, highpriority_in==cur_prio, ptr_nexttask_in≠NULL_PTR and ptr_nexttask_in≠cur_ptr → candidate = ptr_nexttask_in.
    - Else if candidate would equal cur_ptr → IDLE.
    - Else → IDLE.
    - With a candidate: latch cand_ptr and cand_prio=highpriority_in → READ.
  - READ: addr_read_out=cand_ptr → LATCH.
  - LATCH: capture tcb_read_in → next_tcb_out and id_task_in → next_id_out → REQ.
  - REQ: ctxsw_req_out=1 and held, with next_* stable, until ctxsw_ack_in=1 is sampled. On that edge: req=0; cur_ptr=cand_ptr, cur_prio=cand_prio, cur_id_out=next_id_out, cur_valid_out=1 → IDLE.
- ctxsw_ack_in outside REQ is ignored.
- addr_read_out holds its last value outside READ.
- sched_en_in falling:
  - Blocks IDLE→EVAL.
  - A sequence already past IDLE completes.
  - Pending flags are retained.
- Latency: IDLE with pending event to ctxsw_req_out high = 4 cycles (EVAL, READ, LATCH, REQ).
- Preemption arriving during REQ is not applied to the outstanding request. It is evaluated after the ack via chg_pend.
- Priority compare is unsigned 6-bit.

Test Plan:
- Reset, sched_en=1, TICK_DIV=4 → tick_out every 4 cycles; tickval_out 1,2,3…; force tickval 32'hFFFFFFFF → next tick gives 0.
- Empty list (ptr_hpritask=8'hFF), ticks running → ctxsw_req_out never asserts.
- ptr_hpritask=3, prio=5, tcb_read=32'h1000_0300, id=8'h03 → req 4 cycles after change; next_tcb=32'h1000_0300, next_id=3. Hold ack low 10 cycles → req held. Ack → cur_id_out=3, cur_valid=1.
- Running task 3 (prio 5); change to ptr 7, prio 9 → preempt request with id 7. Same scenario with prio 4 → no request.
- Running task 3 (prio 5), ptr_nexttask=4, yield_in pulse → request for task 4. ptr_nexttask=3 → no request.
- Tick during REQ → rr_pend kept, re-evaluated after ack. aresetn low during REQ → req 0 next cycle, all outputs 0.

Source files
------------

// File: rtl/task_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : task_dispatch_scheduler
// Purpose  : Task dispatcher that consumes the ready-list outputs of the list
//            manager, generates the system tick, picks the next task
//            (preemption or round-robin), fetches its TCB address and id over
//            the list manager read port, and holds a context-switch request
//            until the CPU acknowledges it.
// Ports    : aclk / aresetn      clock, synchronous active-low reset
//            sched_en_in         enables the tick counter and new evaluations
//            yield_in            one-cycle software yield
//            highpriority_in     highest ready priority (larger = more urgent)
//            ptr_hpritask_in     head task of the highest priority
//            ptr_nexttask_in     next task at the same priority
//            addr_read_out       TCB read address to the list manager
//            tcb_read_in         TCB address, valid 1 cycle after the address
//            id_task_in          task id, same timing as tcb_read_in
//            tickval_out         free-running tick count (feeds delay list)
//            tick_out            one-cycle pulse per tick
//            ctxsw_req_out       context-switch request, held until ack
//            next_tcb_out        TCB address of the incoming task
//            next_id_out         id of the incoming task
//            ctxsw_ack_in        CPU acknowledge (only sampled in REQ)
//            cur_id_out          id of the running task
//            cur_valid_out       a task is running
// Revision : 1.0  initial release
// ============================================================================
module task_dispatch_scheduler #(
    parameter int unsigned TICK_DIV = 100000,
    parameter logic [7:0]  NULL_PTR = 8'hFF
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        sched_en_in,
    input  logic        yield_in,
    input  logic [5:0]  highpriority_in,
    input  logic [7:0]  ptr_hpritask_in,
    input  logic [7:0]  ptr_nexttask_in,
    output logic [7:0]  addr_read_out,
    input  logic [31:0] tcb_read_in,
    input  logic [7:0]  id_task_in,
    output logic [31:0] tickval_out,
    output logic        tick_out,
    output logic        ctxsw_req_out,
    output logic [31:0] next_tcb_out,
    output logic [7:0]  next_id_out,
    input  logic        ctxsw_ack_in,
    output logic [7:0]  cur_id_out,
    output logic        cur_valid_out
);

    localparam logic [31:0] c_TICK_LAST = TICK_DIV - 32'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EVAL  = 3'd1,
        S_READ  = 3'd2,
        S_LATCH = 3'd3,
        S_REQ   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_tick_cnt;
    logic [31:0] r_tickval;
    logic        r_tick;

    logic        r_rr_pend;
    logic        r_chg_pend;
    logic [5:0]  r_prev_prio;
    logic [7:0]  r_prev_ptr;

    logic [7:0]  r_cand_ptr;
    logic [5:0]  r_cand_prio;
    logic [7:0]  r_cur_ptr;
    logic [5:0]  r_cur_prio;
    logic [7:0]  r_cur_id;
    logic        r_cur_valid;
    logic [7:0]  r_addr;
    logic [31:0] r_next_tcb;
    logic [7:0]  r_next_id;

    logic        w_rr_evt;
    logic        w_chg_evt;
    logic        w_consume;
    logic        w_take;
    logic [7:0]  w_cand_ptr;
    logic        w_commit;

    assign w_rr_evt  = r_tick | yield_in;
    assign w_chg_evt = ({highpriority_in, ptr_hpritask_in} != {r_prev_prio, r_prev_ptr});
    assign w_consume = (r_state == S_EVAL);
    assign w_commit  = (r_state == S_REQ) && ctxsw_ack_in;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and candidate selection
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_take        = 1'b0;
        w_cand_ptr    = ptr_hpritask_in;
        ctxsw_req_out = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sched_en_in && (r_rr_pend || r_chg_pend)) begin
                    w_state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                w_state_nxt = S_IDLE;
                if (ptr_hpritask_in != NULL_PTR) begin
                    if (!r_cur_valid || (highpriority_in > r_cur_prio)) begin
                        w_take     = 1'b1;
                        w_cand_ptr = ptr_hpritask_in;
                    end else if (r_rr_pend && (highpriority_in == r_cur_prio) &&
                                 (ptr_nexttask_in != NULL_PTR) &&
                                 (ptr_nexttask_in != r_cur_ptr)) begin
                        // Round-robin only rotates within the running priority
                        // and only onto a task other than the current one.
                        w_take     = 1'b1;
                        w_cand_ptr = ptr_nexttask_in;
                    end
                end
                if (w_take) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                ctxsw_req_out = 1'b1;
                if (ctxsw_ack_in) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Tick generator
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_tick_cnt <= 32'd0;
            r_tickval  <= 32'd0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (sched_en_in) begin
                if (r_tick_cnt == c_TICK_LAST) begin
                    r_tick_cnt <= 32'd0;
                    r_tickval  <= r_tickval + 32'd1;
                    r_tick     <= 1'b1;
                end else begin
                    r_tick_cnt <= r_tick_cnt + 32'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Event capture; an event in the consuming cycle survives the clear
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rr_pend   <= 1'b0;
            r_chg_pend  <= 1'b0;
            r_prev_prio <= 6'd0;
            r_prev_ptr  <= 8'd0;
        end else begin
            r_rr_pend   <= (r_rr_pend  & ~w_consume) | w_rr_evt;
            r_chg_pend  <= (r_chg_pend & ~w_consume) | w_chg_evt;
            r_prev_prio <= highpriority_in;
            r_prev_ptr  <= ptr_hpritask_in;
        end
    end

    // ------------------------------------------------------------------------
    // Candidate, TCB fetch and current-task datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_cand_ptr  <= 8'd0;
            r_cand_prio <= 6'd0;
            r_addr      <= 8'd0;
            r_next_tcb  <= 32'd0;
            r_next_id   <= 8'd0;
            r_cur_ptr   <= 8'd0;
            r_cur_prio  <= 6'd0;
            r_cur_id    <= 8'd0;
            r_cur_valid <= 1'b0;
        end else begin
            if (w_consume && w_take) begin
                r_cand_ptr  <= w_cand_ptr;
                r_cand_prio <= highpriority_in;
                // Address is presented during READ so the data arrives in LATCH.
                r_addr      <= w_cand_ptr;
            end
            if (r_state == S_LATCH) begin
                r_next_tcb <= tcb_read_in;
                r_next_id  <= id_task_in;
            end
            if (w_commit) begin
                r_cur_ptr   <= r_cand_ptr;
                r_cur_prio  <= r_cand_prio;
                r_cur_id    <= r_next_id;
                r_cur_valid <= 1'b1;
            end
        end
    end

    assign addr_read_out = r_addr;
    assign tickval_out   = r_tickval;
    assign tick_out      = r_tick;
    assign next_tcb_out  = r_next_tcb;
    assign next_id_out   = r_next_id;
    assign cur_id_out    = r_cur_id;
    assign cur_valid_out = r_cur_valid;

endmodule
`default_nettype wire
